waveform_capture: RTL

- Write-side counterpart of the waveform ROM.
- Accepts an 8-bit sample stream over a valid/ready handshake and waits, once armed, for a rising-level trigger.
- After the trigger, writes DEPTH consecutive samples into an internal 256x8 buffer, starting with the triggering sample.
- The picoMIPS test harness reads the buffer back through a registered read port, so software-generated waveforms can be checked against the golden ROM contents.

---
 rtl/wcap_pkg.sv | 19 +
 rtl/wcap_if.sv | 15 +
 rtl/wcap_ram.sv | 37 +++
 rtl/waveform_capture.sv | 133 +++++++++++++
 4 files changed

// File: rtl/wcap_pkg.sv
// Shared types and sizing for the waveform capture block.
// Latency: n/a (types only). Backpressure: n/a.
// Provides state encoding, sample type and default geometry.
package wcap_pkg;

    localparam int WCAP_DATA_W = 8;
    localparam int WCAP_ADDR_W = 8;
    localparam int WCAP_DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } wcap_state_t;

    typedef logic [WCAP_DATA_W-1:0] sample_t;

endpackage

// File: rtl/wcap_if.sv
// Sample stream interface feeding the capture block.
// Latency: n/a (wires only). Backpressure: s_ready driven by the sink.
// master = sample source, slave = capture block.
interface wcap_if
    import wcap_pkg::*;
#(
    parameter int DATA_W = WCAP_DATA_W
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/wcap_ram.sv
// Simple dual-port capture buffer, one write port and one registered read port.
// Latency: 1 cycle read. Backpressure: none, accepts a write every cycle.
// A read and a write to the same address in one cycle return the old word.
module wcap_ram
    import wcap_pkg::*;
#(
    parameter int DATA_W = WCAP_DATA_W,
    parameter int ADDR_W = WCAP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    (* ramstyle = "M9K", romstyle = "M9K" *)
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Nonblocking update of mem gives read-before-write on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/waveform_capture.sv
// Armed rising-level trigger capture of DEPTH samples into a readback buffer; WCAP_DECIM_EN adds decimation.
// Latency: sample written on its accept edge; readback 1 cycle.
// Backpressure: s_ready low only in DONE, stalling the source until re-arm or abort.
module waveform_capture
    import wcap_pkg::*;
#(
    parameter int DATA_W = WCAP_DATA_W,
    parameter int ADDR_W = WCAP_ADDR_W,
    parameter int DEPTH  = WCAP_DEPTH
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_level,
`ifdef WCAP_DECIM_EN
    input  logic [3:0]        decim,
`endif
    wcap_if.slave             s,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    wcap_state_t       state;
    wcap_state_t       state_nxt;
    logic              accept;
    logic              trigger;
    logic              capture_wr;
    logic              last_wr;
    logic              arm_clr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] prev_sample;
    logic              prev_valid;

    assign accept  = s.s_valid && s.s_ready;
    assign trigger = (state == ARMED) && accept && prev_valid &&
                     (prev_sample < trig_level) && (s.s_data >= trig_level);
    assign arm_clr = arm && ((state == IDLE) || (state == DONE));

`ifdef WCAP_DECIM_EN
    logic [3:0] skip_cnt;

    // Trigger sample is phase 0; every (decim+1)th accepted sample after it is kept.
    assign capture_wr = (state == CAPTURE) && accept && (skip_cnt == decim);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            skip_cnt <= '0;
        end else if (trigger) begin
            skip_cnt <= '0;
        end else if ((state == CAPTURE) && accept) begin
            skip_cnt <= (skip_cnt == decim) ? 4'd0 : skip_cnt + 4'd1;
        end
    end
`else
    assign capture_wr = (state == CAPTURE) && accept;
`endif

    assign last_wr = capture_wr && (wr_count == LAST_CNT);
    assign we      = !abort && (trigger || capture_wr);
    assign waddr   = trigger ? '0 : wr_count[ADDR_W-1:0];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (arm)     state_nxt = ARMED;
                ARMED:   if (trigger) state_nxt = CAPTURE;
                CAPTURE: if (last_wr) state_nxt = DONE;
                DONE:    if (arm)     state_nxt = ARMED;
                default:              state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        s.s_ready = (state != DONE);
        busy      = (state == ARMED) || (state == CAPTURE);
        done      = (state == DONE);
    end

    // abort freezes the counters so the partial capture length stays visible.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_count    <= '0;
            prev_valid  <= 1'b0;
            prev_sample <= '0;
        end else if (!abort) begin
            if (arm_clr) begin
                wr_count   <= '0;
                prev_valid <= 1'b0;
            end else if (trigger) begin
                wr_count <= (ADDR_W+1)'(1);
            end else if (capture_wr) begin
                wr_count <= wr_count + 1'b1;
            end
            if ((state == ARMED) && accept) begin
                prev_sample <= s.s_data;
                prev_valid  <= 1'b1;
            end
        end
    end

    wcap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (nReset),
        .we    (we),
        .waddr (waddr),
        .wdata (s.s_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
